// File: rtl/clock_set_ctrl_pkg.sv
// Shared definitions for the clock time-set controller: state encoding and
// the default hold-to-accelerate threshold.
package clock_set_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RUN      = 3'd0,
      ST_HR_SLOW  = 3'd1,
      ST_HR_FAST  = 3'd2,
      ST_MIN_SLOW = 3'd3,
      ST_MIN_FAST = 3'd4
   } set_state_t;

   localparam int DEFAULT_FAST_THRESHOLD = 4;
   localparam int ACCEL_CNT_W            = 4;

endpackage

// File: rtl/clock_set_ctrl_accel_counter.sv
// Saturating slow-set increment counter; o_reached reflects the value the
// counter holds after this cycle's update, so the FSM can switch on that edge.
module set_accel_counter
   import clock_set_ctrl_pkg::*;
#(
   parameter int THRESHOLD = DEFAULT_FAST_THRESHOLD
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_reached
);

   localparam logic [ACCEL_CNT_W-1:0] THRESH = ACCEL_CNT_W'(THRESHOLD);
   localparam logic [ACCEL_CNT_W-1:0] CNT_MAX = '1;

   logic [ACCEL_CNT_W-1:0] count_reg;
   logic [ACCEL_CNT_W-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (i_clr) begin
         count_next = '0;
      end else if (i_inc && (count_reg != CNT_MAX)) begin
         count_next = count_reg + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign o_reached = (count_next >= THRESH);

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set mode controller with hold-to-accelerate; fast-set acceleration is
// built only when CLK_SET_ACCEL_EN is defined.
module clock_set_ctrl
   import clock_set_ctrl_pkg::*;
#(
   parameter int FAST_THRESHOLD = DEFAULT_FAST_THRESHOLD
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_1hz_stb,
   input  logic i_slow_set_stb,
   input  logic i_fast_set_stb,
   input  logic i_set_hours,
   input  logic i_set_minutes,
   output logic o_sec_inc,
   output logic o_min_inc,
   output logic o_hr_inc,
   output logic o_sec_clr,
   output logic o_setting
);

   if ((FAST_THRESHOLD < 1) || (FAST_THRESHOLD > 15)) begin : g_bad_threshold
      $error("clock_set_ctrl: FAST_THRESHOLD must be in 1..15");
   end

   set_state_t state_reg;
   logic       btn_held;
   logic       accel_reached;
   logic       sec_inc_reg, min_inc_reg, hr_inc_reg, sec_clr_reg, setting_reg;

   // Level of whichever button owns the current set state.
   assign btn_held = ((state_reg == ST_HR_SLOW) || (state_reg == ST_HR_FAST)) ?
                     i_set_hours : i_set_minutes;

`ifdef CLK_SET_ACCEL_EN
   logic accel_clr;
   logic accel_inc;

   assign accel_clr = (state_reg == ST_RUN) || !btn_held;
   assign accel_inc = ((state_reg == ST_HR_SLOW) || (state_reg == ST_MIN_SLOW)) &&
                      btn_held && i_slow_set_stb;

   set_accel_counter #(
      .THRESHOLD (FAST_THRESHOLD)
   ) u_accel_counter (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_clr     (accel_clr),
      .i_inc     (accel_inc),
      .o_reached (accel_reached)
   );
`else
   assign accel_reached = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_reg   <= ST_RUN;
         sec_inc_reg <= 1'b0;
         min_inc_reg <= 1'b0;
         hr_inc_reg  <= 1'b0;
         sec_clr_reg <= 1'b0;
         setting_reg <= 1'b0;
      end else begin
         sec_inc_reg <= 1'b0;
         min_inc_reg <= 1'b0;
         hr_inc_reg  <= 1'b0;
         sec_clr_reg <= 1'b0;
         case (state_reg)
            ST_RUN: begin
               // A button press wins over a coincident 1 Hz strobe so that
               // at most one increment strobe is ever active.
               if (i_set_hours) begin
                  state_reg   <= ST_HR_SLOW;
                  hr_inc_reg  <= 1'b1;
                  setting_reg <= 1'b1;
               end else if (i_set_minutes) begin
                  state_reg   <= ST_MIN_SLOW;
                  min_inc_reg <= 1'b1;
                  sec_clr_reg <= 1'b1;
                  setting_reg <= 1'b1;
               end else begin
                  sec_inc_reg <= i_1hz_stb;
                  setting_reg <= 1'b0;
               end
            end
            ST_HR_SLOW, ST_MIN_SLOW: begin
               if (!btn_held) begin
                  state_reg   <= ST_RUN;
                  setting_reg <= 1'b0;
               end else if (i_slow_set_stb) begin
                  if (state_reg == ST_HR_SLOW) begin
                     hr_inc_reg <= 1'b1;
                     if (accel_reached) state_reg <= ST_HR_FAST;
                  end else begin
                     min_inc_reg <= 1'b1;
                     if (accel_reached) state_reg <= ST_MIN_FAST;
                  end
               end
            end
`ifdef CLK_SET_ACCEL_EN
            ST_HR_FAST, ST_MIN_FAST: begin
               if (!btn_held) begin
                  state_reg   <= ST_RUN;
                  setting_reg <= 1'b0;
               end else if (state_reg == ST_HR_FAST) begin
                  hr_inc_reg <= i_fast_set_stb;
               end else begin
                  min_inc_reg <= i_fast_set_stb;
               end
            end
`endif
            default: begin
               state_reg   <= ST_RUN;
               setting_reg <= 1'b0;
            end
         endcase
      end
   end

   assign o_sec_inc = sec_inc_reg;
   assign o_min_inc = min_inc_reg;
   assign o_hr_inc  = hr_inc_reg;
   assign o_sec_clr = sec_clr_reg;
   assign o_setting = setting_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: directed scenarios then random traffic,
// checked cycle by cycle against a behavioural model of the set rules.
module tb_clock_set_ctrl;

   localparam int THR = 4;
`ifdef CLK_SET_ACCEL_EN
   localparam bit ACCEL = 1'b1;
`else
   localparam bit ACCEL = 1'b0;
`endif

   logic clk = 1'b0;
   logic i_reset_n = 1'b0;
   logic i_1hz_stb = 1'b0, i_slow_set_stb = 1'b0, i_fast_set_stb = 1'b0;
   logic i_set_hours = 1'b0, i_set_minutes = 1'b0;
   logic o_sec_inc, o_min_inc, o_hr_inc, o_sec_clr, o_setting;

   always #5 clk = ~clk;

   clock_set_ctrl #(.FAST_THRESHOLD(THR)) dut (
      .i_clk          (clk),
      .i_reset_n      (i_reset_n),
      .i_1hz_stb      (i_1hz_stb),
      .i_slow_set_stb (i_slow_set_stb),
      .i_fast_set_stb (i_fast_set_stb),
      .i_set_hours    (i_set_hours),
      .i_set_minutes  (i_set_minutes),
      .o_sec_inc      (o_sec_inc),
      .o_min_inc      (o_min_inc),
      .o_hr_inc       (o_hr_inc),
      .o_sec_clr      (o_sec_clr),
      .o_setting      (o_setting)
   );

   // Expected outputs packed as {sec_inc, min_inc, hr_inc, sec_clr, setting}.
   logic [4:0] exp_q[$];
   int vectors = 0;
   int miscompares = 0;
   int hr_seen = 0;
   int cycle = 0;

   // Model state: which button owns setting (0 none, 1 hours, 2 minutes)
   // and how many slow-rate increments the current hold has produced.
   int act = 0;
   int slow_cnt = 0;

   task automatic model_push(input bit rst_n, hz, sl, fa, h, m);
      logic [4:0] e;
      bit held, fast_mode, pulse;
      e = '0;
      if (!rst_n) begin
         act = 0;
         slow_cnt = 0;
      end else if (act == 0) begin
         if (h) begin
            act = 1; slow_cnt = 0; e[2] = 1'b1;
         end else if (m) begin
            act = 2; slow_cnt = 0; e[3] = 1'b1; e[1] = 1'b1;
         end else begin
            e[4] = hz;
         end
      end else begin
         held = (act == 1) ? h : m;
         if (!held) begin
            act = 0;
            slow_cnt = 0;
         end else begin
            fast_mode = ACCEL && (slow_cnt >= THR);
            pulse = fast_mode ? fa : sl;
            if (!fast_mode && sl && slow_cnt < 15) slow_cnt++;
            if (pulse) begin
               if (act == 1) e[2] = 1'b1;
               else e[3] = 1'b1;
            end
         end
      end
      e[0] = (act != 0);
      exp_q.push_back(e);
   endtask

   task automatic step(input bit rst_n, hz, sl, fa, h, m);
      @(negedge clk);
      i_reset_n = rst_n; i_1hz_stb = hz; i_slow_set_stb = sl;
      i_fast_set_stb = fa; i_set_hours = h; i_set_minutes = m;
      model_push(rst_n, hz, sl, fa, h, m);
   endtask

   task automatic check_count(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d required %0d", name, got, want);
      end else begin
         $display("check %s: %0d ok", name, got);
      end
   endtask

   // Monitor: one comparison per output cycle.
   initial begin
      logic [4:0] e, got;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {o_sec_inc, o_min_inc, o_hr_inc, o_sec_clr, o_setting};
            vectors++;
            if (o_hr_inc === 1'b1) hr_seen++;
            if (got !== e) begin
               miscompares++;
               $display("FAIL outputs cycle %0d: got sec/min/hr/clr/set=%b required %b",
                        cycle, got, e);
            end else begin
               $display("cycle %0d: outputs %b ok", cycle, got);
            end
         end
      end
   end

   initial begin
      int snap;
      bit h_lvl, m_lvl;
      // Reset, then three 1 Hz strobes with no buttons.
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, 0, 0, 0);
         step(1, 0, 0, 0, 0, 0);
         step(1, 0, 0, 0, 0, 0);
      end

      // Hours held across 6 slow then 5 fast strobes.
      @(posedge clk); #2; snap = hr_seen;
      step(1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) begin
         step(1, 1, 1, 0, 1, 0);
         step(1, 0, 0, 0, 1, 0);
      end
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0, 1, 1, 0);
         step(1, 0, 0, 0, 1, 0);
      end
      step(1, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      check_count("hold_6slow_5fast_hr_inc", hr_seen - snap, ACCEL ? 10 : 7);

      // Minutes: entry pulse, suppressed 1 Hz, release, then 1 Hz resumes.
      step(1, 0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0, 1);
      step(1, 0, 1, 1, 0, 1);
      step(1, 0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);

      // Both buttons together, then release hours with minutes still held.
      step(1, 0, 0, 0, 1, 1);
      step(1, 0, 1, 0, 1, 1);
      step(1, 0, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0);

      // Reach fast rate, then reset coincident with a fast strobe.
      step(1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 1, 0);
      step(1, 0, 0, 1, 1, 0);
      step(0, 0, 0, 1, 1, 0);
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0);
      step(1, 0, 1, 1, 1, 0);
      step(1, 0, 0, 0, 0, 0);

      // Hours across 10 slow and 20 fast strobes.
      @(posedge clk); #2; snap = hr_seen;
      step(1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 1, 0);
      for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 1, 0);
      step(1, 0, 0, 0, 0, 0);
      @(posedge clk); #2;
      check_count("hold_10slow_20fast_hr_inc", hr_seen - snap, ACCEL ? 25 : 11);

      // Random traffic with slowly changing button levels.
      h_lvl = 0; m_lvl = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 24) == 0) h_lvl = ~h_lvl;
         if ($urandom_range(0, 24) == 0) m_lvl = ~m_lvl;
         step($urandom_range(0, 399) != 0,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 2) == 0,
              h_lvl, m_lvl);
      end
      step(1, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #2;
      check_count("scoreboard_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
